// File: rtl/countdown_mod_n.sv
// countdown_mod_n: loadable, cascadable mod-n down-counter with a
// run/pause/done controller.
//
// The count decrements from a loaded value. When the stage wraps
// 0 -> CNT_MAX it emits a registered one-cycle borrow (bout) for the
// next stage. When this stage and all higher stages are zero, it
// emits a registered one-cycle completion pulse (done).
//
// Build option:
//   COUNTDOWN_RELOAD_EN - when defined, DONE reloads cnt from the shadow
//                         copy on the following edge and returns to RUN,
//                         making the block a periodic timer. When
//                         undefined, DONE is sticky until start or load.

module countdown_mod_n #(
  parameter int CNT_BITS = 3,
  parameter int CNT_MAX  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [CNT_BITS:0]   load_data,
  input  logic                start,
  input  logic                pause,
  input  logic                en,
  input  logic                hi_zero,
  output logic [CNT_BITS:0]   cnt,
  output logic                bout,
  output logic                done,
  output logic                busy
);

  localparam int W = CNT_BITS + 1;
  localparam logic [W-1:0] CNT_MAX_V = W'(CNT_MAX);
  localparam logic [W-1:0] ZERO_V    = W'(0);
  localparam logic [W-1:0] ONE_V     = W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Loaded values above the terminal value saturate at CNT_MAX so the
  // count never leaves [0, CNT_MAX].
  function automatic logic [W-1:0] clamp_load(input logic [W-1:0] value);
    if (value > CNT_MAX_V) begin
      return CNT_MAX_V;
    end else begin
      return value;
    end
  endfunction

  // A start only counts when no pause is presented on the same edge.
  function automatic logic start_wins(input logic start_in, input logic pause_in);
    return start_in & ~pause_in;
  endfunction

  state_t         state_r;
  state_t         next_state_s;
  logic [W-1:0]   cnt_r;
  logic [W-1:0]   cnt_next_s;
  logic [W-1:0]   shadow_r;
  logic [W-1:0]   shadow_next_s;
  logic           bout_r;
  logic           bout_next_s;
  logic           done_r;
  logic           done_next_s;
  logic           busy_r;
  logic           busy_next_s;

  // Next-state, next-count and pulse decode; load outranks every state.
  always_comb begin
    next_state_s  = state_r;
    cnt_next_s    = cnt_r;
    shadow_next_s = shadow_r;
    bout_next_s   = 1'b0;
    done_next_s   = 1'b0;

    if (load) begin
      cnt_next_s    = clamp_load(load_data);
      shadow_next_s = clamp_load(load_data);
      next_state_s  = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_wins(start, pause)) begin
            next_state_s = RUN;
          end else begin
            next_state_s = IDLE;
          end
        end

        RUN: begin
          if (pause) begin
            next_state_s = PAUSE;
          end else if (en) begin
            if (cnt_r != ZERO_V) begin
              cnt_next_s = cnt_r - ONE_V;
            end else if (!hi_zero) begin
              // This stage wraps while higher stages still hold a value.
              cnt_next_s  = CNT_MAX_V;
              bout_next_s = 1'b1;
            end else begin
              // Whole chain is zero: finish without a borrow.
              cnt_next_s   = ZERO_V;
              done_next_s  = 1'b1;
              next_state_s = DONE;
            end
          end else begin
            cnt_next_s = cnt_r;
          end
        end

        PAUSE: begin
          if (start_wins(start, pause)) begin
            next_state_s = RUN;
          end else begin
            next_state_s = PAUSE;
          end
        end

        DONE: begin
`ifdef COUNTDOWN_RELOAD_EN
          cnt_next_s   = shadow_r;
          next_state_s = RUN;
`else
          if (start_wins(start, pause)) begin
            cnt_next_s   = shadow_r;
            next_state_s = RUN;
          end else begin
            cnt_next_s   = ZERO_V;
            next_state_s = DONE;
          end
`endif
        end

        default: begin
          next_state_s = IDLE;
          cnt_next_s   = ZERO_V;
        end
      endcase
    end

    busy_next_s = (next_state_s == RUN) || (next_state_s == PAUSE);
  end

  // State, count, shadow and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      cnt_r    <= ZERO_V;
      shadow_r <= ZERO_V;
      bout_r   <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      cnt_r    <= cnt_next_s;
      shadow_r <= shadow_next_s;
      bout_r   <= bout_next_s;
      done_r   <= done_next_s;
      busy_r   <= busy_next_s;
    end
  end

  assign cnt  = cnt_r;
  assign bout = bout_r;
  assign done = done_r;
  assign busy = busy_r;

endmodule
